// File: rtl/sequence_game_core.sv
// Memory-game core: plays a growing prefix of a ROM song, then checks the
// player's presses note by note and accumulates a penalised per-round score.
module sequence_game_core #(
    parameter int NOTES       = 7,
    parameter int ADDR_W      = 4,
    parameter int SONG_W      = 1,
    parameter int NOTE_CYC    = 500,
    parameter int TIMEOUT_CYC = 5000,
    parameter int PENALTY     = 2,
    parameter int MAX_SCORE   = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              level,
    input  logic [SONG_W-1:0] song_sel,
    input  logic [NOTES-1:0]  buttons,
    output logic [SONG_W-1:0] mem_song,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [NOTES-1:0]  mem_data,
    output logic [NOTES-1:0]  leds,
    output logic              tone_valid,
    output logic [ADDR_W-1:0] round,
    output logic [7:0]        errors,
    output logic [6:0]        score,
    output logic              done,
    output logic              timed_out,
    output logic [2:0]        state_dbg
);

    localparam int CNT_MAX = (NOTE_CYC > TIMEOUT_CYC) ? NOTE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int R_LO    = 2 ** (ADDR_W - 1);
    localparam int R_HI    = 2 ** ADDR_W;
    localparam int TRI_LO  = R_LO * (R_LO + 1) / 2;
    localparam int TRI_HI  = R_HI * (R_HI + 1) / 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_P = 3'd1,
        S_SHOW    = 3'd2,
        S_FETCH_I = 3'd3,
        S_WAIT_IN = 3'd4,
        S_CHECK   = 3'd5,
        S_SCORE   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              level_q, level_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] round_q, round_d;
    logic [7:0]        errors_q, errors_d;
    logic [7:0]        round_err_q, round_err_d;
    logic [6:0]        score_q, score_d;
    logic              timed_out_q, timed_out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_any_q, prev_any_d;
    logic [NOTES-1:0]  cap_q, cap_d;

    logic              any_btn;
    logic [ADDR_W-1:0] last_round;
    logic [31:0]       round_num, base, pen, gain, sum_sc;

    assign any_btn    = |buttons;
    assign last_round = level_q ? ADDR_W'(R_HI - 1) : ADDR_W'(R_LO - 1);

    // Score arithmetic is done at 32 bits so nothing wraps before the clamp.
    assign round_num = 32'(round_q) + 32'd1;
    assign base      = level_q ? (round_num * 32'(MAX_SCORE)) / 32'(TRI_HI)
                               : (round_num * 32'(MAX_SCORE)) / 32'(TRI_LO);
    assign pen       = 32'(PENALTY) * 32'(round_err_q);
    assign gain      = (base > pen) ? base - pen : 32'd0;
    assign sum_sc    = 32'(score_q) + gain;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        song_d      = song_q;
        idx_d       = idx_q;
        round_d     = round_q;
        errors_d    = errors_q;
        round_err_d = round_err_q;
        score_d     = score_q;
        timed_out_d = timed_out_q;
        cnt_d       = cnt_q;
        prev_any_d  = prev_any_q;
        cap_d       = cap_q;
        leds        = '0;
        tone_valid  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    level_d     = level;
                    song_d      = song_sel;
                    score_d     = '0;
                    errors_d    = '0;
                    round_err_d = '0;
                    round_d     = '0;
                    idx_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = S_FETCH_P;
                end
            end
            S_FETCH_P: begin
                cnt_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                leds       = mem_data;
                tone_valid = 1'b1;
                if (cnt_q == CNT_W'(NOTE_CYC - 1)) begin
                    if (idx_q < round_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH_P;
                    end else begin
                        idx_d   = '0;
                        state_d = S_FETCH_I;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH_I: begin
                cnt_d      = '0;
                prev_any_d = 1'b0;
                state_d    = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                leds       = buttons;
                tone_valid = any_btn;
                prev_any_d = any_btn;
                if (any_btn && !prev_any_q) begin
                    cap_d   = buttons;
                    state_d = S_CHECK;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (cap_q == mem_data) begin
                    if (idx_q < round_q) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH_I;
                    end else begin
                        state_d = S_SCORE;
                    end
                end else begin
                    // Wrong note: the player retries the same index.
                    errors_d    = (errors_q == 8'hFF) ? errors_q : errors_q + 8'd1;
                    round_err_d = (round_err_q == 8'hFF) ? round_err_q : round_err_q + 8'd1;
                    state_d     = S_FETCH_I;
                end
            end
            S_SCORE: begin
                score_d     = (sum_sc > 32'(MAX_SCORE)) ? 7'(MAX_SCORE) : sum_sc[6:0];
                round_err_d = '0;
                if (round_q == last_round) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 1'b1;
                    idx_d   = '0;
                    state_d = S_FETCH_P;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            level_q     <= 1'b0;
            song_q      <= '0;
            idx_q       <= '0;
            round_q     <= '0;
            errors_q    <= '0;
            round_err_q <= '0;
            score_q     <= '0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
            prev_any_q  <= 1'b0;
            cap_q       <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            song_q      <= song_d;
            idx_q       <= idx_d;
            round_q     <= round_d;
            errors_q    <= errors_d;
            round_err_q <= round_err_d;
            score_q     <= score_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
            prev_any_q  <= prev_any_d;
            cap_q       <= cap_d;
        end
    end

    assign mem_song  = song_q;
    assign mem_addr  = idx_q;
    assign round     = round_q;
    assign errors    = errors_q;
    assign score     = score_q;
    assign done      = (state_q == S_DONE);
    assign timed_out = timed_out_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sequence_game_core.sv
// Bench for sequence_game_core: a ROM model, a scripted player with random
// wrong presses, and a round-by-round score model built from the game rules.
module tb_sequence_game_core;

    localparam int NOTES       = 7;
    localparam int ADDR_W      = 4;
    localparam int SONG_W      = 1;
    localparam int NOTE_CYC    = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int PENALTY     = 2;
    localparam int MAX_SCORE   = 100;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic              clock;
    logic              reset;
    logic              start;
    logic              level;
    logic [SONG_W-1:0] song_sel;
    logic [NOTES-1:0]  buttons;
    logic [SONG_W-1:0] mem_song;
    logic [ADDR_W-1:0] mem_addr;
    logic [NOTES-1:0]  mem_data;
    logic [NOTES-1:0]  leds;
    logic              tone_valid;
    logic [ADDR_W-1:0] round;
    logic [7:0]        errors;
    logic [6:0]        score;
    logic              done;
    logic              timed_out;
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [NOTES-1:0] rom [0:(2**(SONG_W+ADDR_W))-1];
    int score_m, err_m, rounds_m, song_m;

    sequence_game_core #(
        .NOTES(NOTES), .ADDR_W(ADDR_W), .SONG_W(SONG_W), .NOTE_CYC(NOTE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .PENALTY(PENALTY), .MAX_SCORE(MAX_SCORE)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .level(level),
        .song_sel(song_sel), .buttons(buttons), .mem_song(mem_song),
        .mem_addr(mem_addr), .mem_data(mem_data), .leds(leds),
        .tone_valid(tone_valid), .round(round), .errors(errors), .score(score),
        .done(done), .timed_out(timed_out), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_data <= rom[{mem_song, mem_addr}];

    function automatic logic [NOTES-1:0] song_note(input int k);
        return rom[song_m * (2**ADDR_W) + k];
    endfunction

    task automatic wait_wait_in(input string what);
        int n = 0;
        while (state_dbg !== ST_WAIT && n < 200) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (state_dbg !== ST_WAIT) begin
            n_errors++;
            $display("FAIL %s: state %0d after %0d cycles, required %0d", what, state_dbg, n, ST_WAIT);
        end
    endtask

    task automatic begin_game(input bit lvl, input int song);
        @(negedge clock);
        level    = lvl;
        song_sel = SONG_W'(song);
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        rounds_m = lvl ? 2**ADDR_W : 2**(ADDR_W-1);
        song_m   = song;
        score_m  = 0;
        err_m    = 0;
    endtask

    // Records the display from now until the input phase of round r begins.
    task automatic check_playback(input int r, input bit poke_start);
        logic [NOTES-1:0] got_q[$];
        logic [NOTES-1:0] exp_q[$];
        int n = 0;
        int bad = 0;
        int dark_bad = 0;
        while (state_dbg !== ST_WAIT && n < 500) begin
            if (poke_start) start = (n == 3);
            if (!tone_valid && leds !== '0) dark_bad++;
            got_q.push_back(tone_valid ? leds : '0);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        while (got_q.size() > 0 && got_q[0] === '0) void'(got_q.pop_front());
        for (int k = 0; k <= r; k++) begin
            for (int c = 0; c < NOTE_CYC; c++) exp_q.push_back(song_note(k));
            exp_q.push_back('0);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL playback_len r=%0d: got %0d cycles, required %0d", r, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL playback_notes r=%0d: %0d wrong cycles, required 0", r, bad);
            end
        end
        n_checks++;
        if (dark_bad != 0) begin
            n_errors++;
            $display("FAIL dark_leds r=%0d: %0d cycles with leds lit and no tone, required 0", r, dark_bad);
        end
        n_checks++;
        if (round !== ADDR_W'(r) || state_dbg !== ST_WAIT) begin
            n_errors++;
            $display("FAIL round_entry: round %0d state %0d, required round %0d state %0d", round, state_dbg, r, ST_WAIT);
        end
        n_checks++;
        if (score !== 7'(score_m) || errors !== 8'(err_m)) begin
            n_errors++;
            $display("FAIL running_totals r=%0d: score %0d errors %0d, required %0d %0d", r, score, errors, score_m, err_m);
        end
    endtask

    task automatic press(input logic [NOTES-1:0] value);
        wait_wait_in("press_wait");
        repeat ($urandom_range(0, 3)) @(negedge clock);
        buttons = value;
        #1;
        n_checks++;
        if (leds !== value || tone_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL echo: leds %h tone %b, required %h 1", leds, tone_valid, value);
        end
        @(negedge clock);
        buttons = '0;
    endtask

    task automatic play_inputs(input int r, input int err_pct, input int forced_first);
        int rerr = 0;
        int base, g, tri_n;
        logic [NOTES-1:0] note, w;
        for (int k = 0; k <= r; k++) begin
            int nerr = 0;
            note = song_note(k);
            while ((k == 0 && nerr < forced_first) ||
                   (nerr < 2 && int'($urandom_range(0, 99)) < err_pct)) begin
                do w = NOTES'($urandom_range(1, (2**NOTES) - 1)); while (w == note);
                press(w);
                nerr++;
                rerr++;
                if (err_m < 255) err_m++;
            end
            press(note);
        end
        tri_n   = rounds_m * (rounds_m + 1) / 2;
        base    = (r + 1) * MAX_SCORE / tri_n;
        g       = base - PENALTY * rerr;
        if (g < 0) g = 0;
        score_m = (score_m + g > MAX_SCORE) ? MAX_SCORE : score_m + g;
    endtask

    task automatic finish_game();
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (done !== 1'b1 || timed_out !== 1'b0) begin
            n_errors++;
            $display("FAIL game_end: done %b timed_out %b, required 1 0", done, timed_out);
        end
        n_checks++;
        if (score !== 7'(score_m) || errors !== 8'(err_m)) begin
            n_errors++;
            $display("FAIL final_totals: score %0d errors %0d, required %0d %0d", score, errors, score_m, err_m);
        end
        n_checks++;
        if (round !== ADDR_W'(rounds_m - 1) || leds !== '0 || tone_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL final_outputs: round %0d leds %h tone %b, required %0d 0 0", round, leds, tone_valid, rounds_m - 1);
        end
    endtask

    task automatic play_game(input bit lvl, input int song, input int err_pct,
                             input int timeout_round, input int poke_round);
        begin_game(lvl, song);
        for (int r = 0; r < rounds_m; r++) begin
            check_playback(r, r == poke_round);
            if (r == timeout_round) begin
                int n = 0;
                while (done !== 1'b1 && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                n_checks++;
                if (n != TIMEOUT_CYC) begin
                    n_errors++;
                    $display("FAIL timeout_len: %0d cycles to done, required %0d", n, TIMEOUT_CYC);
                end
                n_checks++;
                if (done !== 1'b1 || timed_out !== 1'b1 || round !== ADDR_W'(r)) begin
                    n_errors++;
                    $display("FAIL timeout_flags: done %b timed_out %b round %0d, required 1 1 %0d", done, timed_out, round, r);
                end
                n_checks++;
                if (score !== 7'(score_m) || errors !== 8'(err_m)) begin
                    n_errors++;
                    $display("FAIL timeout_totals: score %0d errors %0d, required %0d %0d", score, errors, score_m, err_m);
                end
                return;
            end
            play_inputs(r, err_pct, 0);
        end
        finish_game();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (state_dbg !== ST_IDLE || done !== 1'b0 || round !== '0) begin
            n_errors++;
            $display("FAIL reset_with_start: state %0d done %b round %0d, required 0 0 0", state_dbg, done, round);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (mem_addr !== '0 || leds !== '0 || tone_valid !== 1'b0 || score !== '0 ||
            errors !== '0 || timed_out !== 1'b0 || state_dbg !== ST_IDLE) begin
            n_errors++;
            $display("FAIL reset_outputs: addr %0d leds %h tone %b score %0d errors %0d to %b state %0d, required all 0",
                     mem_addr, leds, tone_valid, score, errors, timed_out, state_dbg);
        end
    endtask

    task automatic test_perfect_level0();
        play_game(1'b0, 0, 0, -1, -1);
        n_checks++;
        if (score !== 7'd96 || errors !== 8'd0) begin
            n_errors++;
            $display("FAIL perfect_level0: score %0d errors %0d, required 96 0", score, errors);
        end
    endtask

    task automatic test_one_error();
        begin_game(1'b0, 1);
        check_playback(0, 1'b0);
        play_inputs(0, 0, 1);
        check_playback(1, 1'b1);
        n_checks++;
        if (errors !== 8'd1 || score !== 7'd0 || round !== ADDR_W'(1)) begin
            n_errors++;
            $display("FAIL one_error: errors %0d score %0d round %0d, required 1 0 1", errors, score, round);
        end
        play_inputs(1, 40, 0);
        for (int r = 2; r < rounds_m; r++) begin
            check_playback(r, 1'b0);
            play_inputs(r, 40, 0);
        end
        finish_game();
    endtask

    task automatic test_timeout();
        play_game(1'b0, 1, 0, 2, -1);
        n_checks++;
        if (score !== 7'd7) begin
            n_errors++;
            $display("FAIL timeout_score: score %0d, required 7", score);
        end
    endtask

    task automatic test_reset_mid_show();
        int n = 0;
        begin_game(1'b0, 0);
        for (int r = 0; r < 3; r++) begin
            check_playback(r, 1'b0);
            play_inputs(r, 20, 0);
        end
        while (tone_valid !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (state_dbg !== ST_IDLE || mem_addr !== '0 || leds !== '0 || tone_valid !== 1'b0 ||
            round !== '0 || errors !== '0 || score !== '0 || done !== 1'b0 || timed_out !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_show_reset: state %0d addr %0d leds %h tone %b round %0d errors %0d score %0d done %b, required all 0",
                     state_dbg, mem_addr, leds, tone_valid, round, errors, score, done);
        end
        reset = 1'b0;
        play_game(1'b0, 0, 0, -1, -1);
    endtask

    task automatic test_level1_perfect();
        play_game(1'b1, 0, 0, -1, 3);
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 3; g++) begin
            play_game(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(10, 50)), -1, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**(SONG_W+ADDR_W); i++) rom[i] = NOTES'(1) << $urandom_range(0, NOTES - 1);
        reset    = 1'b1;
        start    = 1'b0;
        level    = 1'b0;
        song_sel = '0;
        buttons  = '0;
        test_reset();
        test_perfect_level0();
        test_one_error();
        test_timeout();
        test_level1_perfect();
        test_reset_mid_show();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sequence_game_core.md
SEQUENCE_GAME_CORE -- requirements
Module: sequence_game_core

Interface
REQ-001 Parameter NOTES, default 7, button/note vector width (one-hot notes).
REQ-002 Parameter ADDR_W, default 4, song address width; full song length 2^ADDR_W notes.
REQ-003 Parameter SONG_W, default 1, song-select width (2^SONG_W songs).
REQ-004 Parameter NOTE_CYC, default 500, cycles each note is shown during playback.
REQ-005 Parameter TIMEOUT_CYC, default 5000, cycles allowed per player input.
REQ-006 Parameter PENALTY, default 2, points subtracted per error in a round.
REQ-007 Parameter MAX_SCORE, default 100, score ceiling, at most 127.
REQ-008 clock  in  1  single clock; all state changes on its rising edge.
REQ-009 reset  in  1  synchronous, active-high; sampled only on clock rising edge.
REQ-010 start  in  1  pulse starting a game; honoured only in IDLE or DONE.
REQ-011 level  in  1  0: R = 2^(ADDR_W-1) rounds; 1: R = 2^ADDR_W rounds; sampled at start.
REQ-012 song_sel  in  SONG_W  song choice; sampled at start.
REQ-013 buttons  in  NOTES  player buttons, already synchronised.
REQ-014 mem_song  out  SONG_W  latched song_sel.
REQ-015 mem_addr  out  ADDR_W  note index into external synchronous ROM.
REQ-016 mem_data  in  NOTES  ROM word, valid exactly one cycle after mem_addr/mem_song change.
REQ-017 leds  out  NOTES  displayed note (playback) or button echo (input).
REQ-018 tone_valid  out  1  high when leds carries a note to be sounded.
REQ-019 round  out  ADDR_W  current round index r, 0-based.
REQ-020 errors  out  8  total errors this game, saturating at 255.
REQ-021 score  out  7  accumulated score.
REQ-022 done  out  1  high for the whole DONE state; timed_out  out  1  set when DONE was entered via timeout.

Function
REQ-023 FSM states: IDLE, FETCH_P, SHOW, FETCH_I, WAIT_IN, CHECK, SCORE, DONE; FETCH_P, FETCH_I, CHECK and SCORE last exactly one cycle.
REQ-024 IDLE/DONE + start: latch level, song_sel; clear score, errors, round, index, timed_out; go FETCH_P with index 0.
REQ-025 mem_addr always equals internal index counter.
REQ-026 FETCH_P -> SHOW; SHOW drives leds = mem_data, tone_valid = 1 for NOTE_CYC cycles.
REQ-027 SHOW end: if index < r, index+1 and go FETCH_P; else index = 0, go FETCH_I.
REQ-028 FETCH_I -> WAIT_IN; timeout counter cleared on each WAIT_IN entry.
REQ-029 WAIT_IN: leds = buttons, tone_valid = OR(buttons); press = rising edge of OR(buttons) (registered prior value, cleared on state entry); buttons value captured on press cycle; go CHECK next cycle.
REQ-030 CHECK: match iff captured == mem_data exactly (multi-button presses never match).
REQ-031 Match and index < r: index+1, go FETCH_I; match and index == r: go SCORE.
REQ-032 Mismatch: round_err+1 and errors+1 (both saturating), index unchanged, go FETCH_I (player retries same note).
REQ-033 WAIT_IN for TIMEOUT_CYC cycles without press: set timed_out, go DONE; score not updated for that round.
REQ-034 SCORE: base = floor((r+1)*MAX_SCORE / (R*(R+1)/2)); gain = base - PENALTY*round_err if positive else 0; score = min(score+gain, MAX_SCORE); round_err cleared.
REQ-035 After SCORE: if r == R-1 go DONE; else r+1, index 0, go FETCH_P.
REQ-036 Arithmetic at minimum 16-bit intermediate width; no truncation before the min/saturate steps.
REQ-037 start outside IDLE/DONE ignored; reset and start in same cycle: reset wins.
REQ-038 leds = 0, tone_valid = 0 in IDLE, FETCH_P, FETCH_I, CHECK, SCORE, DONE.

Reset
REQ-039 reset forces IDLE from any state, mid-game included; mem_addr, leds, tone_valid, round, errors, score, done, timed_out all 0 on the following cycle.

Verification
REQ-040 Defaults but NOTE_CYC=4, TIMEOUT_CYC=20, level=0, perfect correct play all 8 rounds -> done=1, score=96, errors=0, timed_out=0.
REQ-041 Round 0, one wrong press then correct -> errors=1, round-0 gain 0 (base 2 - 2), score stays 0, round advances to 1.
REQ-042 No press for 20 cycles in WAIT_IN of round 2 -> timed_out=1, done=1, score equals rounds 0-1 sum (7).
REQ-043 level=1, perfect play -> 16 rounds, score = sum of floor((r+1)*100/136), capped at 100.
REQ-044 reset asserted mid-SHOW of round 3 -> next cycle all outputs 0, state IDLE; start begins fresh game at round 0.
REQ-045 Playback of round r=2: exactly 3 notes from addresses 0,1,2, each tone_valid high 4 cycles, separated by one-cycle FETCH_P gaps.
